// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the multi-cycle instruction sequencer:
// FSM states, control word layout, ALU operation codes and opcodes.
package cpu_seq_pkg;

    localparam int DEFAULT_TIMEOUT = 255;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } t_seq_state;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } t_alu_op;

    typedef struct packed {
        t_alu_op    alu_op;
        logic       sel_alu_imm;
        logic       sel_alu_pc;
        logic       sel_dmem_wb;
        logic       sel_wb;
        logic       sel_next_pc_alu_out;
        logic       reg_wr_en;
        logic       mem_wr_en;
        logic [3:0] mem_byt_en;
    } t_ctrl;

    // Byte lanes for SB/SH/SW, selected by the low bits of funct3
    function automatic logic [3:0] store_byte_en(input logic [1:0] size);
        case (size)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/cpu_decoder.sv
// Pure combinational opcode/funct decode into the datapath control word.
// Write enables are left clear; the sequencer owns them per state.
module cpu_decoder
    import cpu_seq_pkg::*;
(
    input  logic [31:0] instr,
    output t_ctrl       ctrl,
    output logic        legal
);

    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic       funct7_b5_s;
    logic       unused_bits_s;

    assign opcode_s      = instr[6:0];
    assign funct3_s      = instr[14:12];
    assign funct7_b5_s   = instr[30];
    assign unused_bits_s = ^{instr[31], instr[29:15], instr[11:7]};

    // Opcode to control word
    always_comb begin
        ctrl  = '0;
        legal = 1'b0;
        case (opcode_s)
            OP_R: begin
                legal       = 1'b1;
                ctrl.alu_op = t_alu_op'({funct7_b5_s, funct3_s});
            end
            OP_IALU: begin
                legal            = 1'b1;
                ctrl.sel_alu_imm = 1'b1;
                ctrl.alu_op      = t_alu_op'({(funct3_s == 3'b101) & funct7_b5_s, funct3_s});
            end
            OP_LOAD: begin
                legal            = 1'b1;
                ctrl.sel_alu_imm = 1'b1;
                ctrl.sel_dmem_wb = 1'b1;
                ctrl.mem_byt_en  = 4'b1111;
            end
            OP_STORE: begin
                legal            = 1'b1;
                ctrl.sel_alu_imm = 1'b1;
                ctrl.mem_byt_en  = store_byte_en(funct3_s[1:0]);
            end
            OP_JAL: begin
                legal                    = 1'b1;
                ctrl.sel_alu_imm         = 1'b1;
                ctrl.sel_alu_pc          = 1'b1;
                ctrl.sel_wb              = 1'b1;
                ctrl.sel_next_pc_alu_out = 1'b1;
            end
            OP_JALR: begin
                legal                    = 1'b1;
                ctrl.sel_alu_imm         = 1'b1;
                ctrl.sel_wb              = 1'b1;
                ctrl.sel_next_pc_alu_out = 1'b1;
            end
            OP_AUIPC: begin
                legal            = 1'b1;
                ctrl.sel_alu_imm = 1'b1;
                ctrl.sel_alu_pc  = 1'b1;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/cpu_seq.sv
// Multi-cycle fetch/decode/execute sequencer with ack timeouts and sticky halt.
// Outputs are registered from the next state except pc_en, which marks retirement.
module cpu_seq
    import cpu_seq_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    input  logic        dmem_ack,
    output t_ctrl       ctrl,
    output logic [31:0] instr_q,
    output logic        pc_en,
    output logic        halted,
    output logic        err_illegal,
    output logic        err_timeout,
    output logic [31:0] retired
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    t_seq_state       state_r, state_nxt_s;
    logic [31:0]      instr_r, retired_r;
    logic [CNT_W-1:0] wait_cnt_r;
    logic             halted_r, err_illegal_r, err_timeout_r, imem_req_r, dmem_req_r;
    t_ctrl            ctrl_r, ctrl_nxt_s, dec_ctrl_s;
    logic             dec_legal_s, is_load_s, is_store_s, wait_done_s;
    logic             timeout_s, illegal_s, retire_s;

    cpu_decoder u_decoder (
        .instr (instr_r),
        .ctrl  (dec_ctrl_s),
        .legal (dec_legal_s)
    );

    assign is_load_s   = (instr_r[6:0] == OP_LOAD);
    assign is_store_s  = (instr_r[6:0] == OP_STORE);
    assign wait_done_s = (wait_cnt_r == TIMEOUT_CNT);
    assign retire_s    = (state_r == ST_WB) || ((state_r == ST_MEM) && is_store_s && dmem_ack);

    // Next-state selection; an ack on the last allowed cycle wins over the timeout
    always_comb begin
        state_nxt_s = state_r;
        timeout_s   = 1'b0;
        illegal_s   = 1'b0;
        case (state_r)
            ST_IDLE:   state_nxt_s = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack) begin
                    state_nxt_s = ST_DECODE;
                end else if (wait_done_s) begin
                    state_nxt_s = ST_HALT;
                    timeout_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (dec_legal_s) begin
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_HALT;
                    illegal_s   = 1'b1;
                end
            end
            ST_EXEC: begin
                if (is_load_s || is_store_s) begin
                    state_nxt_s = ST_MEM;
                end else begin
                    state_nxt_s = ST_WB;
                end
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    state_nxt_s = is_store_s ? ST_FETCH : ST_WB;
                end else if (wait_done_s) begin
                    state_nxt_s = ST_HALT;
                    timeout_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_MEM;
                end
            end
            ST_WB:     state_nxt_s = ST_FETCH;
            ST_HALT:   state_nxt_s = ST_HALT;
            default:   state_nxt_s = ST_HALT;
        endcase
    end

    // Control word for the upcoming state; zero outside EXEC/MEM/WB
    always_comb begin
        ctrl_nxt_s = '0;
        if (state_nxt_s inside {ST_EXEC, ST_MEM, ST_WB}) begin
            ctrl_nxt_s           = dec_ctrl_s;
            ctrl_nxt_s.reg_wr_en = (state_nxt_s == ST_WB);
            ctrl_nxt_s.mem_wr_en = (state_nxt_s == ST_MEM) && is_store_s;
        end else begin
            ctrl_nxt_s = '0;
        end
    end

    // Sequencer state, instruction register, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            instr_r       <= 32'd0;
            wait_cnt_r    <= '0;
            retired_r     <= 32'd0;
            halted_r      <= 1'b0;
            err_illegal_r <= 1'b0;
            err_timeout_r <= 1'b0;
            imem_req_r    <= 1'b0;
            dmem_req_r    <= 1'b0;
            ctrl_r        <= '0;
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == ST_FETCH) && imem_ack) begin
                instr_r <= imem_rdata;
            end
            if ((state_nxt_s == state_r) && ((state_r == ST_FETCH) || (state_r == ST_MEM))) begin
                wait_cnt_r <= wait_cnt_r + CNT_W'(1);
            end else begin
                wait_cnt_r <= '0;
            end
            if (retire_s) begin
                retired_r <= retired_r + 32'd1;
            end
            halted_r      <= halted_r | (state_nxt_s == ST_HALT);
            err_illegal_r <= err_illegal_r | illegal_s;
            err_timeout_r <= err_timeout_r | timeout_s;
            imem_req_r    <= (state_nxt_s == ST_FETCH);
            dmem_req_r    <= (state_nxt_s == ST_MEM);
            ctrl_r        <= ctrl_nxt_s;
        end
    end

    assign imem_req    = imem_req_r;
    assign dmem_req    = dmem_req_r;
    assign ctrl        = ctrl_r;
    assign instr_q     = instr_r;
    assign pc_en       = retire_s;
    assign halted      = halted_r;
    assign err_illegal = err_illegal_r;
    assign err_timeout = err_timeout_r;
    assign retired     = retired_r;

endmodule

// File: tb/tb_cpu_seq.sv
// Bench for cpu_seq: per-cycle comparison against a transaction-level model,
// a decode table, randomized instruction streams and timeout/reset corners.
module tb_cpu_seq;
    import cpu_seq_pkg::*;

    localparam int TO = 6;

    logic        clk = 1'b0;
    logic        rst_n, imem_req, imem_ack, dmem_req, dmem_ack, pc_en;
    logic        halted, err_illegal, err_timeout;
    logic [31:0] imem_rdata, instr_q, retired;
    t_ctrl       ctrl;

    always #5 clk = ~clk;

    cpu_seq #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .ctrl(ctrl), .instr_q(instr_q), .pc_en(pc_en), .halted(halted),
        .err_illegal(err_illegal), .err_timeout(err_timeout), .retired(retired)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] m_instr, m_retired;
    logic        m_halted, m_ill, m_to;
    t_ctrl       exec_ctrl;
    int          n_dreq, n_pcen;

    typedef struct {
        logic [31:0] ins;
        logic [3:0]  alu;
        logic        imm, pc, dwb, wb, npc;
        logic [3:0]  byt;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode written directly from the opcode rules
    function automatic logic ref_decode(input logic [31:0] ins, output t_ctrl c);
        logic [6:0] op;
        int f3, f7b, alu;
        op  = ins[6:0];
        f3  = int'(ins[14:12]);
        f7b = int'(ins[30]);
        c   = '0;
        if (!(op inside {OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_AUIPC}))
            return 1'b0;
        alu = 0;
        if (op == OP_R) alu = f7b * 8 + f3;
        if (op == OP_IALU) alu = f3 + ((f3 == 5) ? f7b * 8 : 0);
        c.alu_op              = t_alu_op'(4'(alu));
        c.sel_alu_imm         = (op != OP_R);
        c.sel_alu_pc          = (op == OP_JAL) || (op == OP_AUIPC);
        c.sel_dmem_wb         = (op == OP_LOAD);
        c.sel_wb              = (op == OP_JAL) || (op == OP_JALR);
        c.sel_next_pc_alu_out = (op == OP_JAL) || (op == OP_JALR);
        if (op == OP_LOAD) c.mem_byt_en = 4'b1111;
        if (op == OP_STORE) c.mem_byt_en = (f3 == 0) ? 4'b0001 : (f3 == 1) ? 4'b0011 : 4'b1111;
        return 1'b1;
    endfunction

    function automatic t_ctrl exp_ctrl(input t_seq_state st);
        t_ctrl c;
        logic  lg;
        if (!(st inside {ST_EXEC, ST_MEM, ST_WB})) return '0;
        lg          = ref_decode(m_instr, c);
        c.reg_wr_en = (st == ST_WB) && lg;
        c.mem_wr_en = (st == ST_MEM) && (m_instr[6:0] == OP_STORE);
        return c;
    endfunction

    task automatic check_outputs(input t_seq_state st, input logic da);
        logic store;
        store = (m_instr[6:0] == OP_STORE);
        chk("state", 32'(dut.state_r), 32'(st));
        chk("imem_req", 32'(imem_req), 32'(st == ST_FETCH));
        chk("dmem_req", 32'(dmem_req), 32'(st == ST_MEM));
        chk("ctrl", 32'(ctrl), 32'(exp_ctrl(st)));
        chk("pc_en", 32'(pc_en), 32'((st == ST_WB) || (st == ST_MEM && store && da)));
        chk("instr_q", instr_q, m_instr);
        chk("retired", retired, m_retired);
        chk("halted", 32'(halted), 32'(m_halted));
        chk("err_illegal", 32'(err_illegal), 32'(m_ill));
        chk("err_timeout", 32'(err_timeout), 32'(m_to));
    endtask

    // One clock: drive acks (random where they must be ignored) and check outputs
    task automatic cyc(input t_seq_state st, input logic ia, input logic [31:0] rd, input logic da);
        logic da_v;
        @(posedge clk);
        #1;
        imem_ack   = (st == ST_FETCH) ? ia : 1'($urandom_range(0, 1));
        imem_rdata = (st == ST_FETCH && ia) ? rd : $urandom();
        da_v       = (st == ST_MEM) ? da : 1'($urandom_range(0, 1));
        dmem_ack   = da_v;
        #1;
        check_outputs(st, da_v);
        if (dmem_req) n_dreq++;
        if (pc_en) n_pcen++;
        if (st == ST_EXEC) exec_ctrl = ctrl;
    endtask

    task automatic model_reset();
        m_instr = 32'd0; m_retired = 32'd0;
        m_halted = 1'b0; m_ill = 1'b0; m_to = 1'b0;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = 32'd0;
        @(posedge clk);
        #2;
        model_reset();
        check_outputs(ST_IDLE, 1'b0);
        rst_n = 1'b1;
        #1;
        check_outputs(ST_IDLE, 1'b0);
    endtask

    // One instruction from FETCH entry: iw/dw are cycles before each ack
    task automatic run_instr(input logic [31:0] ins, input int iw, input int dw);
        t_ctrl c;
        logic  lg;
        for (int k = 0; k <= TO; k++) begin
            cyc(ST_FETCH, k == iw, ins, 1'b0);
            if (k == iw) break;
        end
        if (iw > TO) begin
            m_halted = 1'b1; m_to = 1'b1;
            cyc(ST_HALT, 1'b0, 32'd0, 1'b0);
            return;
        end
        m_instr = ins;
        lg = ref_decode(ins, c);
        cyc(ST_DECODE, 1'b0, 32'd0, 1'b0);
        if (!lg) begin
            m_halted = 1'b1; m_ill = 1'b1;
            cyc(ST_HALT, 1'b0, 32'd0, 1'b0);
            return;
        end
        cyc(ST_EXEC, 1'b0, 32'd0, 1'b0);
        if (ins[6:0] == OP_LOAD || ins[6:0] == OP_STORE) begin
            for (int k = 0; k <= TO; k++) begin
                cyc(ST_MEM, 1'b0, 32'd0, k == dw);
                if (k == dw) break;
            end
            if (dw > TO) begin
                m_halted = 1'b1; m_to = 1'b1;
                cyc(ST_HALT, 1'b0, 32'd0, 1'b0);
                return;
            end
            if (ins[6:0] == OP_STORE) begin
                m_retired++;
                return;
            end
        end
        cyc(ST_WB, 1'b0, 32'd0, 1'b0);
        m_retired++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[14];
        logic [6:0]  ops[7];
        logic [31:0] ins;
        localparam logic [31:0] ADD_I = 32'h002081B3;
        localparam logic [31:0] LW_I  = 32'h0000A283;
        localparam logic [31:0] SW_I  = 32'h0020A023;

        tbl[0]  = '{32'h002081B3, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000}; // ADD
        tbl[1]  = '{32'h402081B3, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000}; // SUB
        tbl[2]  = '{32'h4020D1B3, 4'b1101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000}; // SRA
        tbl[3]  = '{32'h4030D093, 4'b1101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000}; // SRAI
        tbl[4]  = '{32'h0030D093, 4'b0101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000}; // SRLI
        tbl[5]  = '{32'h40008093, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000}; // ADDI, bit30 set
        tbl[6]  = '{32'h0020C093, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000}; // XORI
        tbl[7]  = '{32'h0000A283, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1111}; // LW
        tbl[8]  = '{32'h00208023, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001}; // SB
        tbl[9]  = '{32'h00209023, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0011}; // SH
        tbl[10] = '{32'h0020A023, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111}; // SW
        tbl[11] = '{32'h008000EF, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000}; // JAL
        tbl[12] = '{32'h000080E7, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000}; // JALR
        tbl[13] = '{32'h00001117, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000}; // AUIPC
        ops = '{OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_AUIPC};

        reset_dut();
        for (int i = 0; i < 14; i++) begin
            run_instr(tbl[i].ins, (i == 0) ? 0 : int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
            chk($sformatf("tbl%0d_alu", i), 32'(exec_ctrl.alu_op), 32'(tbl[i].alu));
            chk($sformatf("tbl%0d_imm", i), 32'(exec_ctrl.sel_alu_imm), 32'(tbl[i].imm));
            chk($sformatf("tbl%0d_pc", i), 32'(exec_ctrl.sel_alu_pc), 32'(tbl[i].pc));
            chk($sformatf("tbl%0d_dwb", i), 32'(exec_ctrl.sel_dmem_wb), 32'(tbl[i].dwb));
            chk($sformatf("tbl%0d_wb", i), 32'(exec_ctrl.sel_wb), 32'(tbl[i].wb));
            chk($sformatf("tbl%0d_npc", i), 32'(exec_ctrl.sel_next_pc_alu_out), 32'(tbl[i].npc));
            chk($sformatf("tbl%0d_byt", i), 32'(exec_ctrl.mem_byt_en), 32'(tbl[i].byt));
        end

        // SW with the data ack three cycles late
        n_dreq = 0; n_pcen = 0;
        run_instr(SW_I, 0, 3);
        chk("sw_dreq_cycles", 32'(n_dreq), 32'd4);
        chk("sw_pcen_pulses", 32'(n_pcen), 32'd1);

        // Randomized legal instruction stream
        for (int i = 0; i < 40; i++) begin
            ins = $urandom();
            ins[6:0] = ops[$urandom_range(0, 6)];
            if (ins[6:0] == OP_STORE) ins[14:12] = 3'($urandom_range(0, 2));
            run_instr(ins, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        // Reset pulse in the middle of a LOAD's MEM phase
        cyc(ST_FETCH, 1'b1, LW_I, 1'b0);
        m_instr = LW_I;
        cyc(ST_DECODE, 1'b0, 32'd0, 1'b0);
        cyc(ST_EXEC, 1'b0, 32'd0, 1'b0);
        cyc(ST_MEM, 1'b0, 32'd0, 1'b0);
        cyc(ST_MEM, 1'b0, 32'd0, 1'b0);
        chk("pre_reset_retired_nonzero", 32'(retired != 32'd0), 32'd1);
        dmem_ack = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs(ST_IDLE, 1'b0);
        rst_n = 1'b1;
        run_instr(ADD_I, 0, 0);

        // Illegal opcode: absorbing HALT with random acks
        reset_dut();
        run_instr(32'hFFFFFFFF, 1, 0);
        for (int i = 0; i < 5; i++) cyc(ST_HALT, 1'b0, 32'd0, 1'b0);

        // Fetch timeout, then acks exactly on the last allowed cycle
        reset_dut();
        run_instr(ADD_I, TO + 3, 0);
        for (int i = 0; i < 3; i++) cyc(ST_HALT, 1'b0, 32'd0, 1'b0);
        reset_dut();
        run_instr(ADD_I, TO, 0);
        run_instr(LW_I, 0, TO);
        run_instr(SW_I, 1, TO);
        run_instr(LW_I, 0, TO + 1);
        for (int i = 0; i < 3; i++) cyc(ST_HALT, 1'b0, 32'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
